// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared encodings and FSM state type for the sequential magnitude comparator.
// Result codes are the 8-bit compare encoding; the top sign-extends them to RES_W.
package seq_magnitude_comparator_pkg;

    localparam logic [7:0] CMP_EQ = 8'h00;
    localparam logic [7:0] CMP_GT = 8'h01;
    localparam logic [7:0] CMP_LT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Pick the 8-bit compare code from the slice-compare flags.
    function automatic logic [7:0] cmp_code(input logic gt, input logic lt);
        if (gt) begin
            return CMP_GT;
        end else if (lt) begin
            return CMP_LT;
        end
        return CMP_EQ;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result handshake bundle for seq_magnitude_comparator.
// master drives operands and takes results; slave is the comparator.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int RES_W = 8
);
    localparam int CNT_W = $clog2(WIDTH / CHUNK + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [CNT_W-1:0] chunks_used;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, result, eq, gt, lt, chunks_used
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, result, eq, gt, lt, chunks_used
    );

endinterface

// File: rtl/seq_magnitude_comparator_cmp_chunk.sv
// Combinational CHUNK-bit slice compare; flip_msb turns the slice into a
// two's-complement compare by inverting the sign bit of both operands.
module seq_magnitude_comparator_cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_s,
    input  logic [CHUNK-1:0] b_s,
    input  logic             flip_msb,
    output logic             gt,
    output logic             lt
);

    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] a_m;
    logic [CHUNK-1:0] b_m;

    assign a_m = a_s ^ (flip_msb ? MSB_MASK : '0);
    assign b_m = b_s ^ (flip_msb ? MSB_MASK : '0);
    assign gt  = (a_m > b_m);
    assign lt  = (a_m < b_m);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans operands MSB-first one CHUNK slice
// per clock and stops at the first differing slice.
module seq_magnitude_comparator
    import seq_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int RES_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_magnitude_comparator_if.slave   bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NSLOT  = 1 << IDX_W;
    localparam int CNT_W  = $clog2(NCHUNK + 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_width
            $fatal(1, "seq_magnitude_comparator: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             signed_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [RES_W-1:0] result_reg;
    logic             eq_reg;
    logic             gt_reg;
    logic             lt_reg;

    // Slice table padded to a power of two so idx_reg indexes it without range gaps.
    logic [CHUNK-1:0] a_slices [NSLOT];
    logic [CHUNK-1:0] b_slices [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slice
            if (gi < NCHUNK) begin : g_real
                assign a_slices[gi] = a_reg[gi*CHUNK +: CHUNK];
                assign b_slices[gi] = b_reg[gi*CHUNK +: CHUNK];
            end else begin : g_pad
                assign a_slices[gi] = '0;
                assign b_slices[gi] = '0;
            end
        end
    endgenerate

    logic slice_gt;
    logic slice_lt;
    logic flip_msb;

    assign flip_msb = signed_reg && (idx_reg == IDX_W'(NCHUNK - 1));

    seq_magnitude_comparator_cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_cmp_chunk (
        .a_s      (a_slices[idx_reg]),
        .b_s      (b_slices[idx_reg]),
        .flip_msb (flip_msb),
        .gt       (slice_gt),
        .lt       (slice_lt)
    );

    function automatic logic [RES_W-1:0] widen(input logic [7:0] code);
        return RES_W'($signed(code));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            signed_reg    <= 1'b0;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            eq_reg        <= 1'b0;
            gt_reg        <= 1'b0;
            lt_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.a;
                        b_reg        <= bus.b;
                        signed_reg   <= bus.signed_mode;
                        idx_reg      <= IDX_W'(NCHUNK - 1);
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (slice_gt || slice_lt || (idx_reg == '0)) begin
                        result_reg    <= widen(cmp_code(slice_gt, slice_lt));
                        eq_reg        <= !(slice_gt || slice_lt);
                        gt_reg        <= slice_gt;
                        lt_reg        <= slice_lt;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.result      = result_reg;
    assign bus.eq          = eq_reg;
    assign bus.gt          = gt_reg;
    assign bus.lt          = lt_reg;
    assign bus.chunks_used = cnt_reg;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: vector table, random ops against a plain
// arithmetic model, backpressure and mid-scan reset, plus an 8/8 instance.
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator_if #(.WIDTH(16), .CHUNK(4), .RES_W(8)) bus16 ();
    seq_magnitude_comparator_if #(.WIDTH(8),  .CHUNK(8), .RES_W(8)) bus8 ();

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4), .RES_W(8)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    seq_magnitude_comparator #(.WIDTH(8), .CHUNK(8), .RES_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [7:0]  res;
        int          lat;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: ordinary integer compare; latency = position of first differing slice.
    task automatic model16(input logic [15:0] a, input logic [15:0] b, input logic s,
                           output logic [7:0] res, output int lat);
        int sa, sb;
        sa = s ? int'($signed(a)) : int'({16'h0, a});
        sb = s ? int'($signed(b)) : int'({16'h0, b});
        res = (sa > sb) ? 8'h01 : (sa < sb) ? 8'hFF : 8'h00;
        lat = 4;
        for (int k = 0; k < 4; k++) begin
            if ((a >> (12 - 4 * k)) != (b >> (12 - 4 * k))) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic s);
        chk("in_ready_before_accept", 32'(bus16.in_ready), 32'd1);
        bus16.a = a;
        bus16.b = b;
        bus16.signed_mode = s;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
    endtask

    task automatic wait_done16(output int lat);
        lat = 0;
        while (!bus16.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run16(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [7:0] res, input int lat_exp);
        int lat;
        start16(a, b, s);
        wait_done16(lat);
        $display("op %s a=%h b=%h s=%0d -> result=%h lat=%0d chunks=%0d",
                 nm, a, b, s, bus16.result, lat, bus16.chunks_used);
        chk({nm, "_latency"}, 32'(lat), 32'(lat_exp));
        chk({nm, "_result"}, 32'(bus16.result), 32'(res));
        chk({nm, "_flags"}, {29'd0, bus16.eq, bus16.gt, bus16.lt},
            {29'd0, res == 8'h00, res == 8'h01, res == 8'hFF});
        chk({nm, "_chunks"}, 32'(bus16.chunks_used), 32'(lat_exp));
        chk({nm, "_in_ready_busy"}, 32'(bus16.in_ready), 32'd0);
        bus16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus16.out_ready = 1'b0;
        chk({nm, "_release"}, {30'd0, bus16.out_valid, bus16.in_ready}, 32'b01);
    endtask

    task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] res);
        int lat;
        chk({nm, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
        bus8.a = a;
        bus8.b = b;
        bus8.signed_mode = s;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("op %s a=%h b=%h s=%0d -> result=%h lat=%0d", nm, a, b, s, bus8.result, lat);
        chk({nm, "_latency"}, 32'(lat), 32'd1);
        chk({nm, "_result"}, 32'(bus8.result), 32'(res));
        chk({nm, "_chunks"}, 32'(bus8.chunks_used), 32'd1);
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus8.out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        logic [7:0]  mres;
        int          mlat;

        vt[0] = '{16'h1234, 16'h1234, 1'b0, 8'h00, 4};
        vt[1] = '{16'h8000, 16'h7FFF, 1'b0, 8'h01, 1};
        vt[2] = '{16'h8000, 16'h7FFF, 1'b1, 8'hFF, 1};
        vt[3] = '{16'h12F4, 16'h12F5, 1'b0, 8'hFF, 4};
        vt[4] = '{16'hFFFF, 16'hFFFE, 1'b1, 8'h01, 4};
        vt[5] = '{16'h0000, 16'hFFFF, 1'b1, 8'h01, 1};
        vt[6] = '{16'h0000, 16'hFFFF, 1'b0, 8'hFF, 1};
        vt[7] = '{16'h1204, 16'h1234, 1'b0, 8'hFF, 3};
        vt[8] = '{16'hA5C3, 16'hA4C3, 1'b1, 8'h01, 2};

        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0;
        bus16.signed_mode = 1'b0; bus16.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0;
        bus8.signed_mode = 1'b0; bus8.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {25'd0, bus16.in_ready, bus16.out_valid, bus16.eq, bus16.gt, bus16.lt,
                            bus16.chunks_used[1:0]}, {25'd0, 7'b1000000});
        chk("reset_result", 32'(bus16.result), 32'd0);
        chk("reset_chunks", 32'(bus16.chunks_used), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run16($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].s, vt[i].res, vt[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? (ra ^ (16'h1 << $urandom_range(15, 0))) : 16'($urandom);
            if (i % 7 == 0) rb = ra;
            rs = 1'($urandom);
            model16(ra, rb, rs, mres, mlat);
            run16($sformatf("rnd%0d", i), ra, rb, rs, mres, mlat);
        end

        // Backpressure: result held in DONE while inputs churn.
        start16(16'h8000, 16'h7FFF, 1'b1);
        wait_done16(mlat);
        chk("bp_latency", 32'(mlat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus16.in_valid = 1'($urandom);
            bus16.a = 16'($urandom);
            bus16.b = 16'($urandom);
            @(posedge clk);
            #1;
            $display("bp cycle %0d out_valid=%0d result=%h in_ready=%0d",
                     i, bus16.out_valid, bus16.result, bus16.in_ready);
            chk("bp_hold", {20'd0, bus16.out_valid, bus16.in_ready, bus16.eq, bus16.gt, bus16.lt,
                            bus16.result[7:1]}, {20'd0, 5'b10001, 7'h7F});
            chk("bp_chunks", 32'(bus16.chunks_used), 32'd1);
        end
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus16.out_ready = 1'b0;
        chk("bp_release", {30'd0, bus16.out_valid, bus16.in_ready}, 32'b01);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_no_new_op", {30'd0, bus16.out_valid, bus16.in_ready}, 32'b01);
        end

        // Reset during the second SCAN cycle abandons the operation.
        start16(16'h5555, 16'h5555, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("abort: in_ready=%0d out_valid=%0d result=%h", bus16.in_ready, bus16.out_valid,
                 bus16.result);
        chk("abort_state", {27'd0, bus16.in_ready, bus16.out_valid, bus16.eq, bus16.gt, bus16.lt},
            {27'd0, 5'b10000});
        chk("abort_result", 32'(bus16.result), 32'd0);
        chk("abort_chunks", 32'(bus16.chunks_used), 32'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("abort_no_output", 32'(bus16.out_valid), 32'd0);
        end
        run16("after_abort", 16'h0001, 16'h0002, 1'b0, 8'hFF, 4);

        run8("w8_signed", 8'h80, 8'h01, 1'b1, 8'hFF);
        run8("w8_unsigned", 8'h80, 8'h01, 1'b0, 8'h01);
        run8("w8_equal", 8'h3C, 8'h3C, 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
